// File: rtl/if_id_latch.sv
// IF/ID pipeline latch: holds the fetched instruction for decode, detects load-use
// hazards against the load in EX, and inserts bubbles on stall or branch flush.
module if_id_latch #(
    parameter logic [31:0] NOP_INST = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] FromIF_NewPC,
    input  logic [31:0] FromIF_Inst,
    input  logic [3:0]  FromIF_InstNum,
    input  logic        FromEX_MemRead,
    input  logic [4:0]  FromEX_Rt,
    input  logic        FromMEM_BranchTaken,
    output logic        Stall,
    output logic [31:0] EndStageID_NewPC,
    output logic [31:0] EndStageID_Inst,
    output logic [3:0]  EndStageID_InstNum,
    output logic [3:0]  EndStageID_InstType,
    output logic [4:0]  EndStageID_Rs,
    output logic [4:0]  EndStageID_Rt,
    output logic [4:0]  EndStageID_Rd,
    output logic        EndStageID_Valid,
    output logic [1:0]  EndStageID_State,
    output logic [7:0]  BubbleCount
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] T_NONE   = 4'd0;
    localparam logic [3:0] T_R      = 4'd1;
    localparam logic [3:0] T_I      = 4'd2;
    localparam logic [3:0] T_J      = 4'd3;
    localparam logic [3:0] T_LOAD   = 4'd4;
    localparam logic [3:0] T_STORE  = 4'd5;
    localparam logic [3:0] T_BRANCH = 4'd6;

    function automatic logic [3:0] decode_type(input logic [5:0] opcode);
        logic [3:0] t;
        t = T_I;
        case (opcode)
            6'b000000:            t = T_R;
            6'b100011:            t = T_LOAD;
            6'b101011:            t = T_STORE;
            6'b000100, 6'b000101: t = T_BRANCH;
            6'b000010, 6'b000011: t = T_J;
            default:              t = T_I;
        endcase
        return t;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] count);
        return (count == 8'hFF) ? count : count + 8'd1;
    endfunction

    logic [31:0] new_pc_p1;
    logic [31:0] inst_p1;
    logic [3:0]  inst_num_p1;
    logic        vld_p1;
    logic [7:0]  bubble_count;
    state_t      state, state_next;

    logic [3:0]  inst_type;
    logic [4:0]  rs, rt, rd;
    logic        hazard_rs, hazard_rt, stall_raw;

    assign rs = inst_p1[25:21];
    assign rt = inst_p1[20:16];
    assign rd = inst_p1[15:11];

    // ---- stage p1 combinational: decode and load-use hazard detection ----
    always_comb begin
        inst_type = vld_p1 ? decode_type(inst_p1[31:26]) : T_NONE;
        hazard_rs = (FromEX_Rt == rs);
        // Rt is only a source operand for R-type, store data and branch compare.
        hazard_rt = (FromEX_Rt == rt) &&
                    ((inst_type == T_R) || (inst_type == T_STORE) || (inst_type == T_BRANCH));
        stall_raw = vld_p1 && FromEX_MemRead && (FromEX_Rt != 5'd0) &&
                    (inst_type != T_J) && (hazard_rs || hazard_rt);
        Stall     = stall_raw && !FromMEM_BranchTaken && !reset;
    end

    // ---- stage p0 -> p1 latch ----
    always_ff @(posedge clock) begin
        if (reset) begin
            new_pc_p1   <= 32'd0;
            inst_p1     <= NOP_INST;
            inst_num_p1 <= 4'd0;
            vld_p1      <= 1'b0;
        end else if (FromMEM_BranchTaken) begin
            new_pc_p1   <= 32'd0;
            inst_p1     <= NOP_INST;
            inst_num_p1 <= FromIF_InstNum;
            vld_p1      <= 1'b0;
        end else if (!Stall) begin
            new_pc_p1   <= FromIF_NewPC;
            inst_p1     <= FromIF_Inst;
            inst_num_p1 <= FromIF_InstNum;
            vld_p1      <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bubble_count <= 8'd0;
        end else if (Stall || FromMEM_BranchTaken) begin
            bubble_count <= sat_inc(bubble_count);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = RUN;
        if (FromMEM_BranchTaken) state_next = FLUSH;
        else if (Stall)          state_next = HOLD;
    end

    assign EndStageID_NewPC    = new_pc_p1;
    assign EndStageID_Inst     = inst_p1;
    assign EndStageID_InstNum  = inst_num_p1;
    assign EndStageID_InstType = inst_type;
    assign EndStageID_Rs       = rs;
    assign EndStageID_Rt       = rt;
    assign EndStageID_Rd       = rd;
    assign EndStageID_Valid    = vld_p1 && !Stall;
    assign EndStageID_State    = state;
    assign BubbleCount         = bubble_count;

endmodule

// File: tb/tb_if_id_latch.sv
// Scoreboard bench for if_id_latch: a behavioural model predicts every cycle's outputs,
// a monitor compares them against the DUT at the falling edge.
module tb_if_id_latch;

    localparam logic [31:0] NOP = 32'h0000_0021;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] if_pc, if_inst;
    logic [3:0]  if_num;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic        br;

    logic        stall;
    logic [31:0] o_pc, o_inst;
    logic [3:0]  o_num, o_type;
    logic [4:0]  o_rs, o_rt, o_rd;
    logic        o_valid;
    logic [1:0]  o_state;
    logic [7:0]  o_bub;

    if_id_latch #(.NOP_INST(NOP)) dut (
        .clock(clock), .reset(reset),
        .FromIF_NewPC(if_pc), .FromIF_Inst(if_inst), .FromIF_InstNum(if_num),
        .FromEX_MemRead(ex_memread), .FromEX_Rt(ex_rt), .FromMEM_BranchTaken(br),
        .Stall(stall), .EndStageID_NewPC(o_pc), .EndStageID_Inst(o_inst),
        .EndStageID_InstNum(o_num), .EndStageID_InstType(o_type),
        .EndStageID_Rs(o_rs), .EndStageID_Rt(o_rt), .EndStageID_Rd(o_rd),
        .EndStageID_Valid(o_valid), .EndStageID_State(o_state), .BubbleCount(o_bub)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        stall;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [3:0]  num;
        logic [3:0]  itype;
        logic [4:0]  rs, rt, rd;
        logic        valid;
        logic [1:0]  state;
        logic [7:0]  bub;
    } rec_t;

    rec_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cycle = 0;

    // Behavioural model state: what the ID stage currently holds.
    logic [31:0] m_pc, m_inst;
    logic [3:0]  m_num;
    bit          m_v;
    int          m_state;
    int          m_bub;

    function automatic int type_of(bit v, logic [31:0] inst);
        logic [5:0] op;
        op = inst[31:26];
        if (!v) return 0;
        if (op == 6'd0) return 1;
        if (op == 6'b100011) return 4;
        if (op == 6'b101011) return 5;
        if (op == 6'b000100 || op == 6'b000101) return 6;
        if (op == 6'b000010 || op == 6'b000011) return 3;
        return 2;
    endfunction

    // Registers the held instruction actually reads.
    function automatic bit reads_reg(int t, logic [31:0] inst, logic [4:0] r);
        if (t == 0 || t == 3) return 0;
        if (inst[25:21] == r) return 1;
        if ((t == 1 || t == 5 || t == 6) && inst[20:16] == r) return 1;
        return 0;
    endfunction

    task automatic step(input bit rst, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [3:0] num, input bit mr, input logic [4:0] xrt, input bit b);
        rec_t e;
        bit   s;
        int   t;
        reset = rst; if_pc = pc; if_inst = inst; if_num = num;
        ex_memread = mr; ex_rt = xrt; br = b;
        t = type_of(m_v, m_inst);
        s = !rst && !b && m_v && mr && (xrt != 0) && reads_reg(t, m_inst, xrt);
        e.stall = s;
        e.pc = m_pc; e.inst = m_inst; e.num = m_num; e.itype = 4'(t);
        e.rs = m_inst[25:21]; e.rt = m_inst[20:16]; e.rd = m_inst[15:11];
        e.valid = m_v && !s; e.state = 2'(m_state); e.bub = 8'(m_bub);
        exp_q.push_back(e);
        if (rst) begin
            m_pc = 0; m_inst = NOP; m_num = 0; m_v = 0; m_state = 0; m_bub = 0;
        end else begin
            if (s || b) m_bub = (m_bub >= 255) ? 255 : m_bub + 1;
            if (b) begin
                m_pc = 0; m_inst = NOP; m_num = num; m_v = 0; m_state = 2;
            end else if (s) begin
                m_state = 1;
            end else begin
                m_pc = pc; m_inst = inst; m_num = num; m_v = 1; m_state = 0;
            end
        end
        @(posedge clock); #1;
    endtask

    // Monitor: compares DUT outputs with the oldest prediction each cycle.
    initial begin
        rec_t e, a;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{stall, o_pc, o_inst, o_num, o_type, o_rs, o_rt, o_rd, o_valid, o_state, o_bub};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL cycle%0d: got stall=%0b pc=%h inst=%h num=%0d type=%0d rs/rt/rd=%0d/%0d/%0d valid=%0b state=%0d bub=%0d; expected stall=%0b pc=%h inst=%h num=%0d type=%0d rs/rt/rd=%0d/%0d/%0d valid=%0b state=%0d bub=%0d",
                             cycle, a.stall, a.pc, a.inst, a.num, a.itype, a.rs, a.rt, a.rd, a.valid, a.state, a.bub,
                             e.stall, e.pc, e.inst, e.num, e.itype, e.rs, e.rt, e.rd, e.valid, e.state, e.bub);
                end
            end
            cycle++;
        end
    end

    function automatic logic [31:0] rand_inst();
        logic [5:0] ops [8];
        logic [31:0] w;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b000011, 6'b001000};
        w = $urandom;
        w[31:26] = ops[$urandom_range(0, 7)];
        w[25:21] = 5'($urandom_range(0, 3));
        w[20:16] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    localparam logic [31:0] ADD = 32'h00221820;
    localparam logic [31:0] LW  = 32'h8C220000;

    initial begin
        reset = 1; if_pc = 0; if_inst = 0; if_num = 0; ex_memread = 0; ex_rt = 0; br = 0;
        m_pc = 0; m_inst = NOP; m_num = 0; m_v = 0; m_state = 0; m_bub = 0;
        @(posedge clock); #1;
        step(1, 0, 0, 0, 0, 0, 0);
        // add then load-use on its Rt, hold, release
        step(0, 5, ADD, 1, 0, 0, 0);
        step(0, 6, LW, 2, 1, 2, 0);
        step(0, 6, LW, 2, 1, 2, 0);
        step(0, 6, LW, 2, 0, 0, 0);
        // lw held: Rt match is not a hazard
        step(0, 7, ADD, 3, 1, 2, 0);
        step(0, 8, ADD, 4, 0, 0, 0);
        // stall and branch together: flush wins
        step(0, 9, LW, 5, 1, 2, 1);
        step(0, 10, ADD, 6, 1, 2, 0);
        step(0, 11, LW, 7, 0, 0, 0);
        // reset in the middle of a hold
        step(0, 12, ADD, 8, 0, 0, 0);
        step(0, 13, LW, 9, 1, 1, 0);
        step(0, 13, LW, 9, 1, 1, 0);
        step(1, 13, LW, 9, 1, 1, 0);
        step(0, 14, ADD, 10, 0, 0, 0);
        // long branch burst saturates the bubble counter
        for (int i = 0; i < 300; i++)
            step(0, $urandom, rand_inst(), 4'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1);
        step(0, 15, ADD, 11, 1, 2, 0);
        step(0, 16, ADD, 12, 1, 2, 0);
        for (int i = 0; i < 2000; i++)
            step(($urandom_range(0, 63) == 0), $urandom, rand_inst(), 4'($urandom),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0));
        @(negedge clock); #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
